req_grant_client: RTL and testbench

// - Requester side of the one-hot req/gnt arbitration interface: REQS independent channels.
// - Each channel accepts a burst command, raises req_o[k], counts granted beats, then releases.
// - Sits between per-channel command producers and the priority arbiter (req_o -> req_i, gnt_o -> gnt_i).
// - Flags starvation and spurious grants per channel.

---
 rtl/req_grant_pkg.sv | 11 +
 rtl/req_grant_chan.sv | 88 ++++++++
 rtl/req_grant_client.sv | 50 +++++
 tb/tb_req_grant_client.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/req_grant_pkg.sv
// Shared types for the req/gnt requester client.
//   chan_state_t : per-channel FSM state (IDLE -> REQ -> GAP -> IDLE)
package req_grant_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } chan_state_t;

endpackage

// File: rtl/req_grant_chan.sv
// One requester channel: accepts a burst command, holds req until every beat
// has been granted, then idles for one GAP cycle before accepting again.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   cmd_valid    command present       cmd_len   beats-1 of the command
//   cmd_ready    channel idle          req       request to arbiter
//   gnt          grant from arbiter    beat      req & gnt this cycle
//   done         last beat this cycle  starve    waited TIMEOUT cycles, registered
//   spurious     grant seen while not requesting
module req_grant_chan
    import req_grant_pkg::*;
#(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    output logic             req,
    input  logic             gnt,
    output logic             beat,
    output logic             done,
    output logic             starve,
    output logic             spurious
);

    localparam int unsigned REM_W  = LEN_W + 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    chan_state_t       state_q;
    logic [REM_W-1:0]  rem_q;
    logic [WAIT_W-1:0] wait_q;
    logic              starve_q;

    // Status decodes of the registered state; beat/spurious follow gnt in-cycle
    assign cmd_ready = (state_q == ST_IDLE);
    assign req       = (state_q == ST_REQ);
    assign beat      = req & gnt;
    assign done      = beat & (rem_q == REM_W'(1));
    assign spurious  = gnt & ~req;
    assign starve    = starve_q;

    // Channel FSM with remaining-beat and starvation counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            wait_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        // Extra bit keeps an all-ones length from wrapping to zero
                        rem_q   <= REM_W'(cmd_len) + REM_W'(1);
                        wait_q  <= '0;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (gnt) begin
                        rem_q    <= rem_q - REM_W'(1);
                        wait_q   <= '0;
                        starve_q <= 1'b0;
                        if (rem_q == REM_W'(1)) begin
                            state_q <= ST_GAP;
                        end
                    end else if (wait_q != WAIT_W'(TIMEOUT)) begin
                        wait_q <= wait_q + WAIT_W'(1);
                        // Flag rises together with the count reaching TIMEOUT
                        if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                            starve_q <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/req_grant_client.sv
// Requester side of the one-hot req/gnt arbitration interface: REQS fully
// independent channels, each built from one req_grant_chan.
// Ports (bit k belongs to channel k):
//   clk, reset    clock and synchronous active-high reset
//   cmd_valid_i   burst command present    cmd_len_i  beats-1, [k*LEN_W +: LEN_W]
//   cmd_ready_o   channel idle             req_o      to arbiter req_i
//   gnt_i         from arbiter gnt_o       beat_o     beat transferred this cycle
//   done_o        last beat of burst       starve_o   starvation flag
//   spurious_o    grant without request
module req_grant_client
    import req_grant_pkg::*;
#(
    parameter int unsigned REQS    = 4,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REQS-1:0]       cmd_valid_i,
    input  logic [REQS*LEN_W-1:0] cmd_len_i,
    output logic [REQS-1:0]       cmd_ready_o,
    output logic [REQS-1:0]       req_o,
    input  logic [REQS-1:0]       gnt_i,
    output logic [REQS-1:0]       beat_o,
    output logic [REQS-1:0]       done_o,
    output logic [REQS-1:0]       starve_o,
    output logic [REQS-1:0]       spurious_o
);

    // One channel per request line
    for (genvar k = 0; k < REQS; k++) begin : g_chan
        req_grant_chan #(
            .LEN_W   (LEN_W),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .cmd_valid (cmd_valid_i[k]),
            .cmd_len   (cmd_len_i[k*LEN_W +: LEN_W]),
            .cmd_ready (cmd_ready_o[k]),
            .req       (req_o[k]),
            .gnt       (gnt_i[k]),
            .beat      (beat_o[k]),
            .done      (done_o[k]),
            .starve    (starve_o[k]),
            .spurious  (spurious_o[k])
        );
    end

endmodule

// File: tb/tb_req_grant_client.sv
module tb_req_grant_client;

    localparam int unsigned REQS  = 4;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned TMO   = 15;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [REQS-1:0]       cmd_valid_i;
    logic [REQS*LEN_W-1:0] cmd_len_i;
    logic [REQS-1:0]       cmd_ready_o;
    logic [REQS-1:0]       req_o;
    logic [REQS-1:0]       gnt_i;
    logic [REQS-1:0]       beat_o;
    logic [REQS-1:0]       done_o;
    logic [REQS-1:0]       starve_o;
    logic [REQS-1:0]       spurious_o;

    req_grant_client #(.REQS(REQS), .LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid_i (cmd_valid_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_ready_o (cmd_ready_o),
        .req_o       (req_o),
        .gnt_i       (gnt_i),
        .beat_o      (beat_o),
        .done_o      (done_o),
        .starve_o    (starve_o),
        .spurious_o  (spurious_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 requesting, 2 gap; beats left; wait cycles
    int m_ph  [REQS];
    int m_rem [REQS];
    int m_wc  [REQS];
    bit m_stv [REQS];
    bit armed = 1'b0;

    // Outputs sampled in the most recent cycle
    logic [REQS-1:0] s_rdy, s_req, s_beat, s_done, s_starve, s_spur;

    // One clock: apply inputs, compare with the model mid-cycle, advance the model
    task automatic cyc(input logic rst, input logic [REQS-1:0] v,
                       input logic [REQS*LEN_W-1:0] len, input logic [REQS-1:0] g_in,
                       input bit arb);
        logic [REQS-1:0] g;
        logic [REQS-1:0] e_rdy, e_req, e_beat, e_done, e_st, e_spur;
        g = arb ? REQS'(req_o & (~req_o + REQS'(1))) : g_in;
        reset = rst; cmd_valid_i = v; cmd_len_i = len; gnt_i = g;
        #3;
        for (int k = 0; k < REQS; k++) begin
            e_rdy[k]  = (m_ph[k] == 0);
            e_req[k]  = (m_ph[k] == 1);
            e_beat[k] = e_req[k] & g[k];
            e_done[k] = e_beat[k] & (m_rem[k] == 1);
            e_spur[k] = g[k] & ~e_req[k];
            e_st[k]   = m_stv[k];
        end
        s_rdy = cmd_ready_o; s_req = req_o; s_beat = beat_o;
        s_done = done_o; s_starve = starve_o; s_spur = spurious_o;
        if (armed) begin
            check("cmd_ready", 32'(s_rdy),    32'(e_rdy));
            check("req",       32'(s_req),    32'(e_req));
            check("beat",      32'(s_beat),   32'(e_beat));
            check("done",      32'(s_done),   32'(e_done));
            check("starve",    32'(s_starve), 32'(e_st));
            check("spurious",  32'(s_spur),   32'(e_spur));
        end
        @(posedge clk);
        if (rst) begin
            armed = 1'b1;
            for (int k = 0; k < REQS; k++) begin
                m_ph[k] = 0; m_rem[k] = 0; m_wc[k] = 0; m_stv[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < REQS; k++) begin
                if (m_ph[k] == 0) begin
                    if (v[k]) begin
                        m_ph[k]  = 1;
                        m_rem[k] = int'(len[k*LEN_W +: LEN_W]) + 1;
                        m_wc[k]  = 0;
                    end
                end else if (m_ph[k] == 1) begin
                    if (g[k]) begin
                        m_rem[k]--;
                        m_wc[k]  = 0;
                        m_stv[k] = 1'b0;
                        if (m_rem[k] == 0) m_ph[k] = 2;
                    end else begin
                        if (m_wc[k] < TMO) m_wc[k]++;
                        if (m_wc[k] == TMO) m_stv[k] = 1'b1;
                    end
                end else begin
                    m_ph[k] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle_cyc(input logic [REQS-1:0] g);
        cyc(1'b0, '0, '0, g, 1'b0);
    endtask

    initial begin
        int beats3, done_at, bcnt [REQS], dcnt [REQS], spur_seen, guard;
        reset = 1'b1; cmd_valid_i = '0; cmd_len_i = '0; gnt_i = '0;
        for (int k = 0; k < REQS; k++) begin
            m_ph[k] = 0; m_rem[k] = 0; m_wc[k] = 0; m_stv[k] = 1'b0;
        end
        @(negedge clk);
        cyc(1'b1, '0, '0, '0, 1'b0);
        cyc(1'b1, '0, '0, '0, 1'b0);

        // T1: reset in the middle of a 4-beat burst on ch0
        cyc(1'b0, 4'b0001, 16'h0003, '0, 1'b0);
        idle_cyc(4'b0001);
        idle_cyc(4'b0001);
        cyc(1'b1, '0, '0, '0, 1'b0);
        idle_cyc('0);
        check("t1_req",   32'(s_req),  32'h0);
        check("t1_ready", 32'(s_rdy),  32'hF);
        check("t1_done",  32'(s_done), 32'h0);

        // T2: single-beat burst on ch2
        cyc(1'b0, 4'b0100, 16'h0000, '0, 1'b0);
        idle_cyc(4'b0100);
        check("t2_beat", 32'(s_beat[2]), 32'h1);
        check("t2_done", 32'(s_done[2]), 32'h1);
        idle_cyc('0);
        check("t2_gap_req",   32'(s_req[2]), 32'h0);
        check("t2_gap_ready", 32'(s_rdy[2]), 32'h0);
        idle_cyc('0);
        check("t2_ready", 32'(s_rdy[2]), 32'h1);

        // T3: ch1 three beats with grant pattern 1,0,0,1,1
        cyc(1'b0, 4'b0010, 16'h0020, '0, 1'b0);
        beats3 = 0; done_at = 0;
        for (int i = 0; i < 5; i++) begin
            logic [4:0] pat;
            pat = 5'b11001;
            idle_cyc({2'b00, pat[i], 1'b0});
            check("t3_req_held", 32'(s_req[1]), 32'h1);
            beats3 += int'(s_beat[1]);
            if (s_done[1]) done_at = i + 1;
        end
        check("t3_beats",   32'(beats3),  32'd3);
        check("t3_done_at", 32'(done_at), 32'd5);
        idle_cyc('0);

        // T4: ch3 starves for TIMEOUT cycles, then one grant clears the flag
        cyc(1'b0, 4'b1000, 16'h0000, '0, 1'b0);
        for (int i = 0; i < int'(TMO); i++) idle_cyc('0);
        check("t4_pre", 32'(s_starve[3]), 32'h0);
        idle_cyc(4'b1000);
        check("t4_set", 32'(s_starve[3]), 32'h1);
        idle_cyc('0);
        check("t4_clear", 32'(s_starve[3]), 32'h0);
        idle_cyc('0);

        // T5: all channels two beats each behind a fixed-priority arbiter
        for (int k = 0; k < REQS; k++) begin bcnt[k] = 0; dcnt[k] = 0; end
        spur_seen = 0;
        cyc(1'b0, 4'b1111, 16'h1111, '0, 1'b0);
        guard = 0;
        while ((dcnt[0] + dcnt[1] + dcnt[2] + dcnt[3]) < 4 && guard < 60) begin
            cyc(1'b0, '0, '0, '0, 1'b1);
            for (int k = 0; k < REQS; k++) begin
                bcnt[k] += int'(s_beat[k]);
                dcnt[k] += int'(s_done[k]);
            end
            if (s_spur != '0) spur_seen++;
            guard++;
        end
        check("t5_timeout", 32'(guard < 60), 32'h1);
        for (int k = 0; k < REQS; k++) begin
            check("t5_beats", 32'(bcnt[k]), 32'd2);
            check("t5_dones", 32'(dcnt[k]), 32'd1);
        end
        check("t5_spurious", 32'(spur_seen), 32'd0);
        idle_cyc('0);
        idle_cyc('0);

        // T6: grant to an idle channel
        idle_cyc(4'b0100);
        check("t6_spur", 32'(s_spur), 32'h4);
        check("t6_beat", 32'(s_beat), 32'h0);
        idle_cyc('0);
        check("t6_ready", 32'(s_rdy), 32'hF);

        // Random traffic, including rare resets and all-ones lengths
        for (int i = 0; i < 4000; i++) begin
            logic             r;
            logic [REQS-1:0]  v, g;
            logic [15:0]      len;
            r   = ($urandom_range(0, 299) == 0);
            v   = REQS'($urandom);
            len = 16'($urandom);
            for (int k = 0; k < REQS; k++) g[k] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) g = '0;
            cyc(r, v, len, g, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
